// File: rtl/mod_envelope.sv
`default_nettype none
// ============================================================================
//  Module   : mod_envelope
//  Purpose  : ADSR envelope stage. Multiplies each synthesiser sample by a
//             note-gated attack/decay/sustain/release gain (18.14 fixed
//             point) and emits the shaped sample one cycle later.
//  Revision : 1.0  initial release
// ============================================================================
module mod_envelope #(
    parameter int FRAC_BITS = 14
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_sample,
    input  logic        i_sample_valid,
    input  logic        i_gate,
    input  logic [31:0] i_attack_step,
    input  logic [31:0] i_decay_step,
    input  logic [31:0] i_sustain_level,
    input  logic [31:0] i_release_step,
    output logic [31:0] o_sound,
    output logic        o_ready,
    output logic [31:0] o_level,
    output logic [2:0]  o_state,
    output logic        o_active
);

    localparam logic [31:0] ENV_MAX = 32'd1 << FRAC_BITS;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ATTACK  = 3'd1,
        S_DECAY   = 3'd2,
        S_SUSTAIN = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] level_q, level_d;
    logic        gate_q;
    logic [31:0] sound_q;
    logic        ready_q;

    logic        w_rise;
    logic        w_fall;
    logic [31:0] w_sustain;
    logic [32:0] w_attack_sum;
    logic [32:0] w_decay_floor;
    logic signed [63:0] w_prod;

    assign w_rise = i_gate & ~gate_q;
    assign w_fall = ~i_gate & gate_q;

    // Sustain targets above unity gain are pinned to unity.
    assign w_sustain = (i_sustain_level > ENV_MAX) ? ENV_MAX : i_sustain_level;

    // 33-bit sums so the step comparisons can never wrap.
    assign w_attack_sum  = {1'b0, level_q} + {1'b0, i_attack_step};
    assign w_decay_floor = {1'b0, w_sustain} + {1'b0, i_decay_step};

    // Product uses the pre-update level captured on the same valid cycle.
    assign w_prod = 64'($signed(i_sample)) * $signed({32'd0, level_q});

    // Next-state and next-level: gate edges take priority and freeze the level.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        if (w_rise) begin
            state_d = S_ATTACK;
        end else if (w_fall) begin
            if (state_q != S_IDLE) begin
                state_d = S_RELEASE;
            end
        end else if (i_sample_valid) begin
            case (state_q)
                S_ATTACK: begin
                    if ((i_attack_step == 32'd0) || (w_attack_sum >= {1'b0, ENV_MAX})) begin
                        level_d = ENV_MAX;
                        state_d = S_DECAY;
                    end else begin
                        level_d = w_attack_sum[31:0];
                    end
                end
                S_DECAY: begin
                    // level - step <= S  <=>  level <= S + step
                    if ((i_decay_step == 32'd0) || ({1'b0, level_q} <= w_decay_floor)) begin
                        level_d = w_sustain;
                        state_d = S_SUSTAIN;
                    end else begin
                        level_d = level_q - i_decay_step;
                    end
                end
                S_SUSTAIN: begin
                    level_d = w_sustain;
                end
                S_RELEASE: begin
                    if ((i_release_step == 32'd0) || (level_q <= i_release_step)) begin
                        level_d = 32'd0;
                        state_d = S_IDLE;
                    end else begin
                        level_d = level_q - i_release_step;
                    end
                end
                default: begin
                    level_d = 32'd0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Envelope state, level and gate history registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            level_q <= 32'd0;
            gate_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            gate_q  <= i_gate;
        end
    end

    // Output sample register: updates only on valid, so o_sound holds between pulses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sound_q <= 32'd0;
            ready_q <= 1'b0;
        end else begin
            ready_q <= i_sample_valid;
            if (i_sample_valid) begin
                sound_q <= 32'(w_prod >>> FRAC_BITS);
            end
        end
    end

    assign o_sound  = sound_q;
    assign o_ready  = ready_q;
    assign o_level  = level_q;
    assign o_state  = state_q;
    assign o_active = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mod_envelope.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mod_envelope
//  Purpose  : Directed self-checking bench for the ADSR envelope stage.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mod_envelope;

    logic        clk;
    logic        rst;
    logic [31:0] sample;
    logic        sample_valid;
    logic        gate;
    logic [31:0] attack_step;
    logic [31:0] decay_step;
    logic [31:0] sustain_level;
    logic [31:0] release_step;
    logic [31:0] sound;
    logic        ready;
    logic [31:0] level;
    logic [2:0]  state;
    logic        active;

    int errors = 0;
    int checks = 0;

    mod_envelope #(.FRAC_BITS(14)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_sample        (sample),
        .i_sample_valid  (sample_valid),
        .i_gate          (gate),
        .i_attack_step   (attack_step),
        .i_decay_step    (decay_step),
        .i_sustain_level (sustain_level),
        .i_release_step  (release_step),
        .o_sound         (sound),
        .o_ready         (ready),
        .o_level         (level),
        .o_state         (state),
        .o_active        (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d (0x%08h) expected=%0d (0x%08h)",
                   tag, $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    task automatic chk_ls(input string tag, input logic [31:0] exp_level, input logic [2:0] exp_state);
        chk({tag, ".level"}, level, exp_level);
        chk({tag, ".state"}, {29'd0, state}, {29'd0, exp_state});
    endtask

    // Expected values for the 8-sample attack/decay run with sample=100.
    logic [31:0] ad_level [8];
    logic [2:0]  ad_state [8];
    logic [31:0] ad_sound [8];

    initial begin
        ad_level = '{32'd4096, 32'd8192, 32'd12288, 32'd16384,
                     32'd14336, 32'd12288, 32'd10240, 32'd8192};
        ad_state = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3};
        // 100 * pre-update level >> 14
        ad_sound = '{32'd0, 32'd25, 32'd50, 32'd75, 32'd100, 32'd87, 32'd75, 32'd62};

        rst = 1'b1; sample = 32'd0; sample_valid = 1'b0; gate = 1'b0;
        attack_step = 32'd0; decay_step = 32'd0; sustain_level = 32'd0; release_step = 32'd0;

        // Reset for two cycles.
        tick(); tick();
        chk("rst.sound", sound, 32'd0);
        chk("rst.ready", {31'd0, ready}, 32'd0);
        chk_ls("rst", 32'd0, 3'd0);
        chk("rst.active", {31'd0, active}, 32'd0);
        rst = 1'b0;
        tick();

        // Idle: sample passes as zero, ready still pulses.
        sample = 32'd1000; sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        chk("idle.ready", {31'd0, ready}, 32'd1);
        chk("idle.sound", sound, 32'd0);
        chk_ls("idle", 32'd0, 3'd0);
        tick();
        chk("idle.ready_drop", {31'd0, ready}, 32'd0);

        // Attack and decay into sustain.
        attack_step = 32'd4096; decay_step = 32'd2048;
        sustain_level = 32'd8192; release_step = 32'd3000;
        gate = 1'b1;
        tick();
        chk_ls("rise", 32'd0, 3'd1);
        chk("rise.active", {31'd0, active}, 32'd1);
        sample = 32'd100; sample_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_ls($sformatf("ad%0d", i), ad_level[i], ad_state[i]);
            chk($sformatf("ad%0d.ready", i), {31'd0, ready}, 32'd1);
            chk($sformatf("ad%0d.sound", i), sound, ad_sound[i]);
        end

        // Gain math at sustain 8192 (0.5), back-to-back.
        sample = 32'd1000;
        tick();
        chk("gain.pos", sound, 32'd500);
        sample = -32'sd1000;
        tick();
        chk("gain.neg", sound, -32'sd500);
        sample = 32'h7FFF_FFFF;
        tick();
        chk("gain.max", sound, 32'h3FFF_FFFF);
        chk_ls("gain", 32'd8192, 3'd3);
        sample_valid = 1'b0;
        tick();
        chk("gain.ready_drop", {31'd0, ready}, 32'd0);
        chk("gain.hold", sound, 32'h3FFF_FFFF);

        // Release to idle.
        gate = 1'b0;
        tick();
        chk_ls("fall", 32'd8192, 3'd4);
        sample = 32'd16384; sample_valid = 1'b1;
        tick();
        chk_ls("rel0", 32'd5192, 3'd4);
        chk("rel0.sound", sound, 32'd8192);
        tick();
        chk_ls("rel1", 32'd2192, 3'd4);
        tick();
        chk_ls("rel2", 32'd0, 3'd0);
        chk("rel2.active", {31'd0, active}, 32'd0);
        sample_valid = 1'b0;

        // attack_step = 0 jumps to full scale on one valid.
        gate = 1'b1; attack_step = 32'd0;
        tick();
        chk_ls("att0.rise", 32'd0, 3'd1);
        sample_valid = 1'b1;
        tick();
        chk_ls("att0", 32'd16384, 3'd2);

        // Sustain above unity clamps to 16384.
        sustain_level = 32'd20000;
        tick();
        chk_ls("clamp.decay", 32'd16384, 3'd3);
        tick();
        chk_ls("clamp.sus", 32'd16384, 3'd3);
        sustain_level = 32'd8192;
        tick();
        chk_ls("sus.track", 32'd8192, 3'd3);

        // Valid coincident with a falling edge: no step, ready still pulses.
        gate = 1'b0; sample = 32'd2000;
        tick();
        chk_ls("edge", 32'd8192, 3'd4);
        chk("edge.ready", {31'd0, ready}, 32'd1);
        chk("edge.sound", sound, 32'd1000);
        tick();
        chk_ls("retrig.rel", 32'd5192, 3'd4);
        sample_valid = 1'b0;

        // Retrigger during release keeps the level.
        gate = 1'b1; attack_step = 32'd4096;
        tick();
        chk_ls("retrig.rise", 32'd5192, 3'd1);
        sample_valid = 1'b1;
        tick();
        chk_ls("retrig.step", 32'd9288, 3'd1);

        // Reset mid-attack discards the in-flight sample.
        rst = 1'b1;
        tick();
        chk_ls("midrst", 32'd0, 3'd0);
        chk("midrst.ready", {31'd0, ready}, 32'd0);
        chk("midrst.sound", sound, 32'd0);
        rst = 1'b0; sample_valid = 1'b0; gate = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mod_envelope.md
Name: mod_envelope

Overview:
ADSR envelope stage directly downstream of the harmonic synthesiser. Consumes the synthesiser's output sample and its ready pulse, multiplies each sample by a note-gated attack/decay/sustain/release gain, and emits the shaped sample with a one-cycle ready pulse to the output path. The envelope advances once per accepted sample, so envelope timing scales with the sample rate, not the clock.

Parameters:
FRAC_BITS, 14, fractional bits of the gain format; ENV_MAX = 1 << FRAC_BITS represents gain 1.0 (16384 at default).

Ports:
i_clk  input  1  clock.
i_rst  input  1  synchronous reset, active-high.
i_sample  input  32 signed  synthesiser output sample.
i_sample_valid  input  1  one-cycle pulse: i_sample is valid.
i_gate  input  1  note held; level-sensitive, edges detected internally.
i_attack_step  input  32 unsigned  gain increment per sample in ATTACK, 18.14.
i_decay_step  input  32 unsigned  gain decrement per sample in DECAY, 18.14.
i_sustain_level  input  32 unsigned  sustain gain, 18.14; values above ENV_MAX are clamped to ENV_MAX.
i_release_step  input  32 unsigned  gain decrement per sample in RELEASE, 18.14.
o_sound  output  32 signed  enveloped sample.
o_ready  output  1  one-cycle pulse: o_sound is valid.
o_level  output  32 unsigned  current gain, 18.14, range 0..ENV_MAX.
o_state  output  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
o_active  output  1  high whenever o_state != IDLE.

Behaviour:
- Reset, synchronous on i_rst=1: o_sound=0, o_ready=0, o_level=0, o_state=IDLE, o_active=0, registered gate_q=0. Reset takes effect mid-note and discards any in-flight sample, so o_ready=0 on the cycle after reset.
- Gate edges: gate_q registers i_gate every clock.
  - Rising edge (i_gate & ~gate_q): state becomes ATTACK on the next clock from any state. Level is kept (retrigger without a click).
  - Falling edge: state becomes RELEASE from any non-IDLE state. In IDLE, no change.
  - On an edge cycle the level is not stepped, even if i_sample_valid is high.
- Level steps occur only on i_sample_valid cycles with no gate edge. Arithmetic is 33-bit, so there is no wrap-around.
  - ATTACK: level = min(level + attack_step, ENV_MAX). When the result equals ENV_MAX, go to DECAY. attack_step=0 sets the level to ENV_MAX immediately.
  - DECAY: level = max(level - decay_step, S), where S is the clamped sustain level. When the result equals S, go to SUSTAIN. decay_step=0 sets the level to S immediately.
  - SUSTAIN: level = S on every valid, tracking live changes to the sustain input.
  - RELEASE: level = (level > release_step) ? level - release_step : 0. At 0, go to IDLE. release_step=0 sets the level to 0 immediately.
  - IDLE: level held at 0.
- Datapath:
  - On a valid cycle t, capture i_sample and the pre-update level L.
  - At cycle t+1: o_sound = (i_sample * L) >>> FRAC_BITS, computed as a signed 64-bit product with arithmetic shift and truncated to the low 32 bits. o_ready=1 for exactly that cycle.
  - Latency is 1 cycle. Throughput is one sample per clock (back-to-back valids give back-to-back ready pulses).
- o_ready follows every valid in every state, including IDLE (where o_sound=0), so the downstream sample rate stays constant.
- o_sound holds its value between ready pulses.
- o_level and o_state are registered and reflect post-update values.

Test Plan:
- Reset and idle: assert i_rst for 2 cycles, then i_sample=1000 valid with gate=0 -> o_sound=0, o_ready pulses at t+1, o_state=0, o_level=0.
- Attack and decay: gate rises, attack_step=4096, decay_step=2048, sustain=8192, then 8 valids -> o_level sequence 4096, 8192, 12288, 16384 (state DECAY), 14336, 12288, 10240, 8192 (state SUSTAIN).
- Gain math: in SUSTAIN at 8192, samples 1000, -1000, 0x7FFFFFFF -> o_sound 500, -500, 0x3FFFFFFF, each exactly 1 cycle after its valid.
- Release: from SUSTAIN 8192, gate falls, release_step=3000 -> levels 5192, 2192, 0, then state IDLE and o_active=0.
- Retrigger: gate falls during RELEASE at level 5192, then rises -> ATTACK starts from 5192; next valid with attack_step=4096 -> 9288.
- Edge cases: attack_step=0 -> level 16384 after one valid. Sustain=20000 -> clamped to 16384. Valid coincident with a gate edge -> level unchanged, o_ready still pulses. i_rst mid-ATTACK -> next cycle o_level=0, o_state=IDLE, o_ready=0.
